mmcm_reset_seq: RTL and testbench
=================================

// Module: mmcm_reset_seq
// PURPOSE
//  Sequences board-level clock bring-up: pulses MMCM RST, waits for LOCKED with timeout and retry,
//  qualifies lock stability, then releases system reset to the core. Re-sequences on lock loss or
//  a debounced user button. Runs on the raw board oscillator, upstream of the MMCM/BUFG.
//  Consumers in the MMCM output domain re-synchronise sys_rst_n_o locally.
// PARAMETERS
//  DEBOUNCE_CYCLES  240000  cycles btn must be stable before the debounced level changes
//  MMCM_RST_CYCLES  16      cycles mmcm_rst_o is held high per reset pulse (>=1)
//  LOCK_TIMEOUT     1200000 cycles allowed in WAIT_LOCK before a retry
//  STABLE_CYCLES    1024    consecutive locked cycles required before release (>=1)
//  MAX_RETRY        7       timeouts tolerated before entering FAIL (1..15)
// PORTS
//  clk              in   1  board oscillator clock
//  rst_n            in   1  asynchronous active-low reset
//  btn_i            in   1  raw push-button, async, active-high
//  mmcm_locked_i    in   1  MMCM LOCKED, async to clk
//  mmcm_rst_o       out  1  MMCM RST, active-high
//  sys_rst_n_o      out  1  system reset to core, active-low, registered
//  fail_o           out  1  high in FAIL state
//  retry_cnt_o      out  4  WAIT_LOCK timeouts since last RUN entry, saturating at 15
//  lock_loss_cnt_o  out  8  lock losses seen in RUN, saturating at 255; cleared only by rst_n
//  state_o          out  3  current state encoding (below)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RST_MMCM, mmcm_rst_o=1, sys_rst_n_o=0, fail_o=0, all counters 0.
//  Sync: btn_i and mmcm_locked_i each pass a 2-flop synchroniser -> btn_s, lock_s (2-cycle latency).
//  Debounce: btn_db changes only after btn_s differs from btn_db for DEBOUNCE_CYCLES consecutive
//   cycles; any mismatch break restarts the count. btn_db resets to 0.
//  States (state_o): RST_MMCM=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
//  RST_MMCM: mmcm_rst_o=1, sys_rst_n_o=0. Counter holds at 0 while btn_db=1; else counts;
//   after MMCM_RST_CYCLES cycles -> WAIT_LOCK (mmcm_rst_o high exactly MMCM_RST_CYCLES cycles).
//  WAIT_LOCK: mmcm_rst_o=0. lock_s=1 -> STABLE. Timeout after LOCK_TIMEOUT cycles: retry_cnt++;
//   if new retry_cnt >= MAX_RETRY -> FAIL, else -> RST_MMCM.
//  STABLE: lock_s=0 -> WAIT_LOCK (timeout counter restarts, no retry increment).
//   STABLE_CYCLES consecutive lock_s=1 cycles -> RUN.
//  RUN: sys_rst_n_o=1 registered on the RUN entry edge; retry_cnt cleared on entry.
//   lock_s=0 -> sys_rst_n_o=0 at the next edge, lock_loss_cnt++, -> RST_MMCM.
//  FAIL: mmcm_rst_o=0, sys_rst_n_o=0, fail_o=1; exits only via button or rst_n.
//  Button: btn_db rising in any state -> RST_MMCM next edge, sys_rst_n_o=0, fail_o=0,
//   retry_cnt cleared; holding button keeps mmcm_rst_o=1.
//  Priority per cycle: btn_db rise > lock loss (RUN) > timeout > normal progression.
//  Counters are sized by $clog2 of their limit; no wrap in any state counter; saturating status counters.
//  rst_n mid-sequence aborts immediately to reset values; outputs glitch-free (all registered).
// TESTING
//  Params DEBOUNCE=4, MMCM_RST=8, TIMEOUT=100, STABLE=16, MAX_RETRY=3 for all cases.
//  1 Power-up: release rst_n, locked rises 20 cyc after mmcm_rst_o falls -> mmcm_rst_o high 8 cyc,
//    sys_rst_n_o rises 2+16 cyc after locked rises; retry_cnt_o=0.
//  2 Never lock -> 3 timeouts, three 8-cyc RST pulses between, then fail_o=1, state_o=4, retry_cnt_o=3.
//  3 In RUN drop locked -> sys_rst_n_o low 3 edges later, lock_loss_cnt_o=1, new 8-cyc RST pulse.
//  4 Locked glitch low 1 cyc during STABLE -> back to WAIT_LOCK, release only after fresh 16 cyc.
//  5 Button bounce pulses of 2 cyc -> no effect; hold 10 cyc -> RST_MMCM, mmcm_rst_o high
//    through hold plus 8 cyc; from FAIL clears fail_o.
//  6 Assert rst_n during STABLE -> immediate reset values; lock_loss_cnt_o returns to 0.

Source files
------------

// File: rtl/mmcm_reset_seq_if.sv
// rtl/mmcm_reset_seq_if.sv - board bring-up signals between the reset sequencer and the clocking/core side
`timescale 1ns/1ps
interface mmcm_reset_seq_if;
  logic       btn_i;
  logic       mmcm_locked_i;
  logic       mmcm_rst_o;
  logic       sys_rst_n_o;
  logic       fail_o;
  logic [3:0] retry_cnt_o;
  logic [7:0] lock_loss_cnt_o;
  logic [2:0] state_o;

  modport master (
    input  btn_i, mmcm_locked_i,
    output mmcm_rst_o, sys_rst_n_o, fail_o, retry_cnt_o, lock_loss_cnt_o, state_o
  );

  modport slave (
    output btn_i, mmcm_locked_i,
    input  mmcm_rst_o, sys_rst_n_o, fail_o, retry_cnt_o, lock_loss_cnt_o, state_o
  );
endinterface

// File: rtl/mmcm_reset_seq.sv
// rtl/mmcm_reset_seq.sv - MMCM reset pulse, lock wait with retry, lock qualification and system reset release
`timescale 1ns/1ps
module mmcm_reset_seq #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 1200000,
  parameter int STABLE_CYCLES   = 1024,
  parameter int MAX_RETRY       = 7
) (
  input logic              clk,
  input logic              rst_n,
  mmcm_reset_seq_if.master bus
);

  localparam logic [2:0] ST_RST_MMCM  = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RST_W = $clog2(MMCM_RST_CYCLES + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W  = $clog2(STABLE_CYCLES + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(MMCM_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  logic             btn_s1_q, btn_s1_d, btn_s_q, btn_s_d;
  logic             lock_s1_q, lock_s1_d, lock_s_q, lock_s_d;
  logic             btn_db_q, btn_db_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [2:0]       state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [ST_W-1:0]  st_cnt_q, st_cnt_d;
  logic [3:0]       retry_cnt_q, retry_cnt_d;
  logic [7:0]       loss_cnt_q, loss_cnt_d;
  logic             mmcm_rst_q, mmcm_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             fail_q, fail_d;
  logic             btn_rise;
  logic [3:0]       retry_inc;

  // Debounced level flips on the same edge that the sequencer reacts to the rise.
  always_comb begin
    btn_s1_d  = bus.btn_i;
    btn_s_d   = btn_s1_q;
    lock_s1_d = bus.mmcm_locked_i;
    lock_s_d  = lock_s1_q;
    btn_db_d  = btn_db_q;
    db_cnt_d  = '0;
    btn_rise  = 1'b0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s_q;
        btn_rise = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    st_cnt_d    = st_cnt_q;
    retry_cnt_d = retry_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    retry_inc   = (retry_cnt_q == 4'hf) ? retry_cnt_q : retry_cnt_q + 4'd1;

    if (btn_rise) begin
      state_d     = ST_RST_MMCM;
      rst_cnt_d   = '0;
      retry_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RST_MMCM: begin
          if (btn_db_q) begin
            rst_cnt_d = '0;
          end else if (rst_cnt_q == RST_LAST) begin
            state_d  = ST_WAIT_LOCK;
            to_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (to_cnt_q == TO_LAST) begin
            retry_cnt_d = retry_inc;
            rst_cnt_d   = '0;
            state_d     = (retry_inc >= RETRY_LIMIT) ? ST_FAIL : ST_RST_MMCM;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
            // The cycle that first sees lock counts as the first stable cycle.
            if (lock_s_q) begin
              st_cnt_d = ST_W'(1);
              if (STABLE_CYCLES == 1) begin
                state_d     = ST_RUN;
                retry_cnt_d = '0;
              end else begin
                state_d = ST_STABLE;
              end
            end
          end
        end
        ST_STABLE: begin
          if (!lock_s_q) begin
            state_d  = ST_WAIT_LOCK;
            to_cnt_d = '0;
          end else if (st_cnt_q == ST_LAST) begin
            state_d     = ST_RUN;
            retry_cnt_d = '0;
          end else begin
            st_cnt_d = st_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s_q) begin
            state_d    = ST_RST_MMCM;
            rst_cnt_d  = '0;
            loss_cnt_d = (loss_cnt_q == 8'hff) ? loss_cnt_q : loss_cnt_q + 8'd1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d   = ST_RST_MMCM;
          rst_cnt_d = '0;
        end
      endcase
    end

    mmcm_rst_d  = (state_d == ST_RST_MMCM);
    sys_rst_n_d = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q    <= 1'b0;
      btn_s_q     <= 1'b0;
      lock_s1_q   <= 1'b0;
      lock_s_q    <= 1'b0;
      btn_db_q    <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= ST_RST_MMCM;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      st_cnt_q    <= '0;
      retry_cnt_q <= '0;
      loss_cnt_q  <= '0;
      mmcm_rst_q  <= 1'b1;
      sys_rst_n_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      btn_s1_q    <= btn_s1_d;
      btn_s_q     <= btn_s_d;
      lock_s1_q   <= lock_s1_d;
      lock_s_q    <= lock_s_d;
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      st_cnt_q    <= st_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
      mmcm_rst_q  <= mmcm_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.mmcm_rst_o      = mmcm_rst_q;
  assign bus.sys_rst_n_o     = sys_rst_n_q;
  assign bus.fail_o          = fail_q;
  assign bus.retry_cnt_o     = retry_cnt_q;
  assign bus.lock_loss_cnt_o = loss_cnt_q;
  assign bus.state_o         = state_q;

endmodule

// File: tb/tb_mmcm_reset_seq.sv
// tb/tb_mmcm_reset_seq.sv - directed bench for mmcm_reset_seq with small timing parameters
`timescale 1ns/1ps
module tb_mmcm_reset_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mmcm_reset_seq_if bus ();

  mmcm_reset_seq #(
    .DEBOUNCE_CYCLES(4),
    .MMCM_RST_CYCLES(8),
    .LOCK_TIMEOUT   (100),
    .STABLE_CYCLES  (16),
    .MAX_RETRY      (3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.mmcm_rst_o;
      1:       return bus.sys_rst_n_o;
      default: return bus.fail_o;
    endcase
  endfunction

  // Returns the number of ticks until the selected output equals val, or -1 on timeout.
  task automatic ticks_until(input int sel, input logic val, output int n);
    n = -1;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (sig(sel) == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},    int'(bus.state_o), 0);
    check({tag, "_mmcm_rst"}, int'(bus.mmcm_rst_o), 1);
    check({tag, "_sys_rst"},  int'(bus.sys_rst_n_o), 0);
    check({tag, "_fail"},     int'(bus.fail_o), 0);
    check({tag, "_retry"},    int'(bus.retry_cnt_o), 0);
    check({tag, "_loss"},     int'(bus.lock_loss_cnt_o), 0);
  endtask

  initial begin
    int   n;
    int   w;
    logic prev;
    logic cur;
    int   widths[$];
    int   retries[$];

    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    bus.btn_i = 1'b0;
    bus.mmcm_locked_i = 1'b0;
    tick();
    tick();
    check_reset_values("por");

    // Power-up with lock 20 cycles after the RST pulse ends.
    rst_n = 1'b1;
    ticks_until(0, 1'b0, n);
    check("pwr_rst_width", n, 8);
    check("pwr_wait_state", int'(bus.state_o), 1);
    repeat (20) tick();
    bus.mmcm_locked_i = 1'b1;
    ticks_until(1, 1'b1, n);
    check("pwr_release_lat", n, 18);
    check("pwr_run_state", int'(bus.state_o), 3);
    check("pwr_retry", int'(bus.retry_cnt_o), 0);

    // Lock loss in RUN.
    bus.mmcm_locked_i = 1'b0;
    ticks_until(1, 1'b0, n);
    check("loss_lat", n, 3);
    check("loss_cnt", int'(bus.lock_loss_cnt_o), 1);
    check("loss_state", int'(bus.state_o), 0);
    ticks_until(0, 1'b0, n);
    check("loss_rst_width", n, 8);

    // One-cycle lock glitch during STABLE.
    bus.mmcm_locked_i = 1'b1;
    repeat (8) tick();
    check("glitch_pre_state", int'(bus.state_o), 2);
    bus.mmcm_locked_i = 1'b0;
    tick();
    bus.mmcm_locked_i = 1'b1;
    tick();
    tick();
    check("glitch_back_wait", int'(bus.state_o), 1);
    ticks_until(1, 1'b1, n);
    check("glitch_release_lat", n, 16);
    check("glitch_run_state", int'(bus.state_o), 3);

    // rst_n asserted during STABLE.
    bus.mmcm_locked_i = 1'b0;
    ticks_until(1, 1'b0, n);
    check("loss2_lat", n, 3);
    check("loss2_cnt", int'(bus.lock_loss_cnt_o), 2);
    ticks_until(0, 1'b0, n);
    check("loss2_rst_width", n, 8);
    bus.mmcm_locked_i = 1'b1;
    repeat (5) tick();
    check("abort_pre_state", int'(bus.state_o), 2);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");

    // Never lock: three RST pulses then FAIL.
    bus.mmcm_locked_i = 1'b0;
    tick();
    rst_n = 1'b1;
    prev = 1'b0;
    w = 0;
    for (int i = 0; i < 1000; i++) begin
      cur = bus.mmcm_rst_o;
      if (cur && !prev) begin
        w = 1;
        retries.push_back(int'(bus.retry_cnt_o));
      end else if (cur) begin
        w++;
      end else if (prev) begin
        widths.push_back(w);
      end
      prev = cur;
      if (bus.fail_o) break;
      tick();
    end
    check("nolock_pulses", widths.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("nolock_width%0d", k), (k < widths.size()) ? widths[k] : -1, 8);
      check($sformatf("nolock_retry%0d", k), (k < retries.size()) ? retries[k] : -1, k);
    end
    check("fail_flag", int'(bus.fail_o), 1);
    check("fail_state", int'(bus.state_o), 4);
    check("fail_retry", int'(bus.retry_cnt_o), 3);
    check("fail_mmcm_rst", int'(bus.mmcm_rst_o), 0);
    check("fail_sys_rst", int'(bus.sys_rst_n_o), 0);

    // Button bounce has no effect, a held press leaves FAIL.
    for (int k = 0; k < 3; k++) begin
      bus.btn_i = 1'b1;
      tick();
      tick();
      bus.btn_i = 1'b0;
      tick();
      tick();
    end
    check("bounce_fail", int'(bus.fail_o), 1);
    check("bounce_state", int'(bus.state_o), 4);
    bus.btn_i = 1'b1;
    ticks_until(0, 1'b1, n);
    check("btn_rise_lat", n, 6);
    check("btn_fail_clr", int'(bus.fail_o), 0);
    check("btn_state", int'(bus.state_o), 0);
    check("btn_retry_clr", int'(bus.retry_cnt_o), 0);
    repeat (4) tick();
    check("btn_hold_rst", int'(bus.mmcm_rst_o), 1);
    bus.btn_i = 1'b0;
    ticks_until(0, 1'b0, n);
    check("btn_release_lat", n, 14);
    check("btn_wait_state", int'(bus.state_o), 1);
    check("btn_loss_kept", int'(bus.lock_loss_cnt_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
